// File: rtl/mc14500_iobus.sv
// Bit-serial I/O subsystem for the MC14500 ICU: PC, jump register, SRAM shifters, scratch bits, output latches.
// Defining MC14500_IOBUS_SPI_EN builds the SPI byte engine; otherwise sclk_o/sdo_o are driven from the top two scratch bits.
module mc14500_iobus #(
  parameter int   ADDR_W  = 5,
  parameter int   PC_W    = 17,
  parameter int   MAR_W   = 8,
  parameter int   SRAM_AW = 6,
  parameter int   DATA_W  = 8,
  parameter int   N_OUT   = 2,
  parameter logic OUT_RST = 1'b1,
  parameter int   SPI_DIV = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                step_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic                write_i,
  input  logic                data_i,
  input  logic                flag_o_i,
  input  logic                flag_f_i,
  input  logic                jmp_i,
  input  logic                rtn_i,
  output logic                data_in_o,
  output logic [PC_W-1:0]     pc_o,
  output logic [SRAM_AW-1:0]  sram_addr_o,
  output logic [DATA_W-1:0]   sram_din_o,
  input  logic [DATA_W-1:0]   sram_dout_i,
  output logic                sram_we_o,
  output logic [N_OUT-1:0]    out_o,
  input  logic                sdi_i,
  output logic                sclk_o,
  output logic                sdo_o,
  output logic                spi_busy_o
);

  localparam int NS = 2 ** (ADDR_W - 1);

  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   dest_q;
  logic [MAR_W-1:0]  mar_q;
  logic [DATA_W-1:0] dob_q;
  logic [DATA_W-1:0] dia_q;
  logic [DATA_W-1:0] dib_q;
  logic [NS-1:0]     scratch_q;
  logic [N_OUT-1:0]  out_q;

  logic              spi_done;
  logic [DATA_W-1:0] spi_rx;

  logic              hi;
  logic [ADDR_W-2:0] sidx;

  assign hi   = addr_i[ADDR_W-1];
  assign sidx = addr_i[ADDR_W-2:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q      <= '0;
      dest_q    <= '0;
      mar_q     <= '0;
      dob_q     <= '0;
      dia_q     <= '0;
      dib_q     <= '0;
      scratch_q <= '0;
      out_q     <= {N_OUT{OUT_RST}};
    end else begin
      if (step_i) begin
        pc_q <= jmp_i ? dest_q : pc_q + PC_W'(1);
        if (rtn_i)
          mar_q <= '0;
        else if (write_i && addr_i == ADDR_W'(1))
          mar_q <= {mar_q[MAR_W-2:0], data_i};
        if (write_i && addr_i == ADDR_W'(0))
          dest_q <= {dest_q[PC_W-2:0], data_i};
        if (write_i && addr_i == ADDR_W'(2))
          dob_q <= {dob_q[DATA_W-2:0], data_i};
        if (write_i && hi)
          scratch_q[sidx] <= data_i;
        for (int i = 0; i < N_OUT; i++)
          if (write_i && addr_i == ADDR_W'(8 + i))
            out_q[i] <= data_i;
        if (flag_o_i && addr_i == ADDR_W'(2))
          dib_q <= sram_dout_i;
        else if (addr_i == ADDR_W'(4))
          dib_q <= {dib_q[DATA_W-2:0], 1'b0};
      end
      // A finishing SPI transfer owns dia over any ICU-side update that cycle.
      if (spi_done)
        dia_q <= spi_rx;
      else if (step_i && flag_o_i && addr_i == ADDR_W'(1))
        dia_q <= sram_dout_i;
      else if (step_i && addr_i == ADDR_W'(3))
        dia_q <= {dia_q[DATA_W-2:0], 1'b0};
    end
  end

  always_comb begin
    data_in_o = 1'b0;
    if (hi) begin
      data_in_o = scratch_q[sidx];
    end else begin
      if (addr_i == ADDR_W'(0)) data_in_o = 1'b1;
      if (addr_i == ADDR_W'(3)) data_in_o = dia_q[DATA_W-1];
      if (addr_i == ADDR_W'(4)) data_in_o = dib_q[DATA_W-1];
      if (addr_i == ADDR_W'(6)) data_in_o = spi_busy_o;
      if (addr_i == ADDR_W'(7)) data_in_o = sdi_i;
      for (int i = 0; i < N_OUT; i++)
        if (addr_i == ADDR_W'(8 + i))
          data_in_o = out_q[i];
    end
  end

  assign pc_o        = pc_q;
  assign sram_addr_o = mar_q[SRAM_AW-1:0];
  assign sram_din_o  = dob_q;
  assign sram_we_o   = flag_f_i & ~step_i;
  assign out_o       = out_q;

  generate
    if (MAR_W > SRAM_AW) begin : g_mar_hi
      logic unused_mar_hi;
      assign unused_mar_hi = ^mar_q[MAR_W-1:SRAM_AW];
    end
  endgenerate

`ifdef MC14500_IOBUS_SPI_EN
  // state    | meaning
  // SPI_IDLE | waiting for a start strobe at addr 5
  // SPI_XFER | clocking DATA_W bits, sclk toggling every SPI_DIV cycles
  typedef enum logic {SPI_IDLE, SPI_XFER} spi_state_t;

  localparam int DIV_W = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam int BIT_W = $clog2(2 * DATA_W);

  spi_state_t        state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DIV_W-1:0]  div_q;
  logic [BIT_W-1:0]  bit_q;
  logic              sclk_q;
  logic              sdo_q;
  logic              busy_q;
  logic              spi_start;
  logic              tick;

  assign spi_start = step_i & write_i & data_i & (addr_i == ADDR_W'(5)) & (state_q == SPI_IDLE);
  assign tick      = (div_q == '0);
  assign spi_done  = (state_q == SPI_XFER) & tick & (bit_q == '0);
  assign spi_rx    = shift_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SPI_IDLE;
      shift_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        SPI_IDLE: begin
          if (spi_start) begin
            state_q <= SPI_XFER;
            shift_q <= dob_q;
            sdo_q   <= dob_q[DATA_W-1];
            busy_q  <= 1'b1;
            sclk_q  <= 1'b0;
            div_q   <= DIV_W'(SPI_DIV - 1);
            bit_q   <= BIT_W'(2 * DATA_W - 1);
          end
        end
        SPI_XFER: begin
          if (!tick) begin
            div_q <= div_q - DIV_W'(1);
          end else begin
            div_q  <= DIV_W'(SPI_DIV - 1);
            sclk_q <= ~sclk_q;
            // The last toggle is a falling edge: no shift, the byte is complete.
            if (bit_q == '0) begin
              state_q <= SPI_IDLE;
              busy_q  <= 1'b0;
            end else begin
              bit_q <= bit_q - BIT_W'(1);
              if (!sclk_q) begin
                shift_q[0] <= sdi_i;
              end else begin
                shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                sdo_q   <= shift_q[DATA_W-2];
              end
            end
          end
        end
        default: state_q <= SPI_IDLE;
      endcase
    end
  end

  assign sclk_o     = sclk_q;
  assign sdo_o      = sdo_q;
  assign spi_busy_o = busy_q;
`else
  assign spi_done   = 1'b0;
  assign spi_rx     = '0;
  assign spi_busy_o = 1'b0;
  assign sclk_o     = scratch_q[NS-2];
  assign sdo_o      = scratch_q[NS-1];
`endif

endmodule

// File: tb/tb_mc14500_iobus.sv
// Bench for mc14500_iobus (PC_W=4 so PC wrap is reachable); SPI checks follow MC14500_IOBUS_SPI_EN.
module tb_mc14500_iobus;

  logic       clk = 1'b0;
  logic       rst, step, wr, dat, fo, ff, jmp, rtn;
  logic [4:0] addr;
  logic [7:0] sram_dout;
  logic       sdi_r, loop_en;
  logic       sdi_w;

  logic       data_in_o;
  logic [3:0] pc_o;
  logic [5:0] sram_addr_o;
  logic [7:0] sram_din_o;
  logic       sram_we_o;
  logic [1:0] out_o;
  logic       sclk_o, sdo_o, spi_busy_o;

  assign sdi_w = loop_en ? sdo_o : sdi_r;

  always #5 clk = ~clk;

  mc14500_iobus #(.PC_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .step_i(step), .addr_i(addr), .write_i(wr),
    .data_i(dat), .flag_o_i(fo), .flag_f_i(ff), .jmp_i(jmp), .rtn_i(rtn),
    .data_in_o(data_in_o), .pc_o(pc_o), .sram_addr_o(sram_addr_o),
    .sram_din_o(sram_din_o), .sram_dout_i(sram_dout), .sram_we_o(sram_we_o),
    .out_o(out_o), .sdi_i(sdi_w), .sclk_o(sclk_o), .sdo_o(sdo_o),
    .spi_busy_o(spi_busy_o)
  );

  typedef struct {string name; logic [31:0] val;} exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic push(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] act);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0h with no expectation", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h", e.name, act, e.val);
      end
    end
  endtask

  typedef struct {
    logic [4:0] addr;
    logic wr, d, fo, jmp, rtn;
    logic [7:0] sdout;
    logic cd; logic din;
    logic cp; logic [3:0] pc;
    logic cs; logic [5:0] sa;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [4:0] a, input logic w, d, f, j, r, input logic [7:0] so,
                     input logic cd, din, input logic cp, input logic [3:0] pc,
                     input logic cs, input logic [5:0] sa);
    vec_t v;
    v.addr = a; v.wr = w; v.d = d; v.fo = f; v.jmp = j; v.rtn = r; v.sdout = so;
    v.cd = cd; v.din = din; v.cp = cp; v.pc = pc; v.cs = cs; v.sa = sa;
    tbl.push_back(v);
  endtask

  task automatic clr_in();
    step = 0; wr = 0; dat = 0; fo = 0; jmp = 0; rtn = 0;
  endtask

  task automatic do_step(input logic [4:0] a, input logic w, d, f, output logic din);
    @(negedge clk);
    addr = a; wr = w; dat = d; fo = f; step = 1;
    #1 din = data_in_o;
    @(posedge clk);
    #1 clr_in();
  endtask

  task automatic read_byte(input logic [4:0] a, output logic [7:0] b);
    logic bit_v;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      do_step(a, 1'b0, 1'b0, 1'b0, bit_v);
      b = {b[6:0], bit_v};
    end
  endtask

  logic       tmp;
  logic [7:0] byte_v;
  logic [7:0] bits_a5 = 8'hA5;
  logic [7:0] bits_3c = 8'h3C;

  initial begin
    rst = 1; clr_in(); ff = 0; addr = '0; sram_dout = '0; sdi_r = 0; loop_en = 0;
    repeat (3) @(negedge clk);
    push("rst_out", 2'b11);   pop_cmp(out_o);
    push("rst_pc", 0);        pop_cmp(pc_o);
    push("rst_sclk", 0);      pop_cmp(sclk_o);
    push("rst_sdo", 0);       pop_cmp(sdo_o);
    push("rst_busy", 0);      pop_cmp(spi_busy_o);
    rst = 0;
    @(negedge clk);
    ff = 1; #1;
    push("we_ff1", 1);        pop_cmp(sram_we_o);
    ff = 0; #1;
    push("we_ff0", 0);        pop_cmp(sram_we_o);

    for (int i = 1; i <= 5; i++) add(0, 0,0,0,0,0, 0, 1,1, 1,4'(i), 0,0);
    add(0, 1,1,0,0,0, 0, 0,0, 0,0, 0,0);
    add(0, 1,0,0,0,0, 0, 0,0, 0,0, 0,0);
    add(0, 1,1,0,0,0, 0, 0,0, 1,8, 0,0);
    add(9, 0,0,0,1,0, 0, 1,1, 1,5, 0,0);
    for (int i = 7; i >= 0; i--) add(1, 1,bits_a5[i],0,0,0, 0, 0,0, 0,0, i==0,6'h25);
    add(1, 1,1,0,0,1, 0, 0,0, 1,14, 1,0);
    add(1, 0,0,1,0,0, 8'h81, 0,0, 1,15, 0,0);
    for (int i = 0; i < 8; i++) add(3, 0,0,0,0,0, 0, 1,(i==0 || i==7), i==0,0, 0,0);
    add(8, 1,0,0,0,0, 0, 0,0, 0,0, 0,0);
    add(8, 0,0,0,0,0, 0, 1,0, 0,0, 0,0);
    add(9, 0,0,0,0,0, 0, 1,1, 0,0, 0,0);
    add(19, 1,1,0,0,0, 0, 0,0, 0,0, 0,0);
    add(19, 0,0,0,0,0, 0, 1,1, 0,0, 0,0);
    add(20, 0,0,0,0,0, 0, 1,0, 0,0, 0,0);
    add(2, 0,0,0,0,0, 0, 1,0, 0,0, 0,0);
    add(2, 0,0,1,0,0, 8'h80, 0,0, 0,0, 0,0);
    add(4, 0,0,0,0,0, 0, 1,1, 0,0, 0,0);
    add(4, 0,0,0,0,0, 0, 1,0, 0,0, 0,0);
    for (int i = 7; i >= 0; i--) add(2, 1,bits_3c[i],0,0,0, 0, 0,0, 0,0, 0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      addr = tbl[i].addr; wr = tbl[i].wr; dat = tbl[i].d; fo = tbl[i].fo;
      jmp = tbl[i].jmp; rtn = tbl[i].rtn; sram_dout = tbl[i].sdout; step = 1;
      #1;
      if (tbl[i].cd) begin push($sformatf("vec%0d_din", i), tbl[i].din); pop_cmp(data_in_o); end
      @(posedge clk);
      #1 clr_in();
      if (tbl[i].cp) begin push($sformatf("vec%0d_pc", i), tbl[i].pc); pop_cmp(pc_o); end
      if (tbl[i].cs) begin push($sformatf("vec%0d_sram_addr", i), tbl[i].sa); pop_cmp(sram_addr_o); end
    end
    push("dob_sram_din", 8'h3C); pop_cmp(sram_din_o);

`ifdef MC14500_IOBUS_SPI_EN
    begin : spi_run
      int  busy_cnt, nbits;
      logic prev, done;
      logic [7:0] rx;
      loop_en = 1;
      busy_cnt = 0; nbits = 0; prev = 0; done = 0; rx = '0;
      @(negedge clk);
      addr = 5; wr = 1; dat = 1; step = 1;
      for (int c = 0; c < 80 && !done; c++) begin
        @(negedge clk);
        clr_in();
        if (spi_busy_o) busy_cnt++;
        else done = 1;
        if (sclk_o && !prev) begin rx = {rx[6:0], sdo_o}; nbits++; end
        prev = sclk_o;
        if (c == 6)  begin addr = 5; wr = 1; dat = 1; step = 1; end
        if (c == 12) begin addr = 2; wr = 1; dat = 1; step = 1; end
      end
      push("spi_done_in_time", 1); pop_cmp(done);
      push("spi_busy_cycles", 32); pop_cmp(busy_cnt);
      push("spi_sdo_bits", 8);     pop_cmp(nbits);
      push("spi_sdo_seq", 8'h3C);  pop_cmp(rx);
      push("spi_sclk_idle", 0);    pop_cmp(sclk_o);
      read_byte(3, byte_v);
      push("spi_dia", 8'h3C);      pop_cmp(byte_v);

      sram_dout = 8'hFF;
      do_step(1, 1'b0, 1'b0, 1'b1, tmp);
      do_step(5, 1'b1, 1'b1, 1'b0, tmp);
      repeat (9) @(negedge clk);
      push("spi_busy_mid", 1);     pop_cmp(spi_busy_o);
      rst = 1;
      @(negedge clk);
      rst = 0;
      push("mid_rst_sclk", 0);     pop_cmp(sclk_o);
      push("mid_rst_busy", 0);     pop_cmp(spi_busy_o);
      push("mid_rst_out", 2'b11);  pop_cmp(out_o);
      repeat (20) @(negedge clk);
      push("mid_rst_stays_idle", 0); pop_cmp(spi_busy_o);
      read_byte(3, byte_v);
      push("mid_rst_dia", 0);      pop_cmp(byte_v);
      loop_en = 0;
    end
`else
    do_step(31, 1'b1, 1'b1, 1'b0, tmp);
    #1;
    push("bb_sdo", 1);   pop_cmp(sdo_o);
    push("bb_sclk0", 0); pop_cmp(sclk_o);
    do_step(30, 1'b1, 1'b1, 1'b0, tmp);
    #1;
    push("bb_sclk1", 1); pop_cmp(sclk_o);
    do_step(5, 1'b1, 1'b1, 1'b0, tmp);
    repeat (2) @(negedge clk);
    push("bb_busy", 0);  pop_cmp(spi_busy_o);
    do_step(6, 1'b0, 1'b0, 1'b0, tmp);
    push("bb_addr6", 0); pop_cmp(tmp);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
